// File: rtl/aes_crypt_engine.sv
// Iterative AES cipher/inverse cipher with run-time mode, 128/192/256-bit keys and an optional
// two-rounds-per-clock unroll. Round keys come pre-expanded and must stay stable while a block runs.
module aes_crypt_engine #(
  parameter int UNROLL = 1,
  parameter int TAG_W  = 4
) (
  input  logic               eph1,
  input  logic               reset,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic               mode_i,
  input  logic [1:0]         key_size_i,
  input  logic [15:1][127:0] key_words_i,
  input  logic [127:0]       data_i,
  input  logic [TAG_W-1:0]   tag_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [127:0]       data_o,
  output logic [TAG_W-1:0]   tag_o,
  output logic               mode_o,
  output logic               busy_o
);

  if (UNROLL != 1 && UNROLL != 2) begin : g_bad_unroll
    $error("aes_crypt_engine: UNROLL must be 1 or 2");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("aes_crypt_engine: TAG_W must be at least 1");
  end

  localparam logic [3:0] STEP = 4'(UNROLL);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      acc = acc ^ (b[i] ? p : 8'h00);
      p   = xtime(p);
    end
    return acc;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as the S-box needs
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] acc;
    p   = a;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p   = gf_mul(p, p);
      acc = gf_mul(acc, p);
    end
    return acc;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] b;
    b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
    logic [127:0] t;
    for (int n = 0; n < 16; n++) begin
      t[8*n +: 8] = inv ? inv_sbox(s[8*n +: 8]) : sbox(s[8*n +: 8]);
    end
    return t;
  endfunction

  // Byte n sits at [127-8n -: 8]; row = n%4, column = n/4
  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] t;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        t[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((inv ? c - r + 4 : c + r) % 4) + r) -: 8];
      end
    end
    return t;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
    logic [127:0]    t;
    logic [3:0][7:0] k;
    logic [7:0]      b;
    k = inv ? {8'h0e, 8'h0b, 8'h0d, 8'h09} : {8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) begin
        b = 8'h00;
        for (int j = 0; j < 4; j++) begin
          b = b ^ gf_mul(s[127 - 8*(4*c + (i + j) % 4) -: 8], k[3-j]);
        end
        t[127 - 8*(4*c + i) -: 8] = b;
      end
    end
    return t;
  endfunction

  // Round r of either cipher; decrypt walks the key schedule backwards
  function automatic logic [127:0] do_round(input logic [127:0] s, input logic inv,
                                            input logic [3:0] r, input logic [3:0] n,
                                            input logic [15:1][127:0] kw);
    logic [3:0]   idx;
    logic [127:0] t;
    idx = inv ? n - r : r;
    if (inv) begin
      t = sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ kw[4'd15 - idx];
      t = (r != n) ? mix_columns(t, 1'b1) : t;
    end else begin
      t = shift_rows(sub_bytes(s, 1'b0), 1'b0);
      t = ((r != n) ? mix_columns(t, 1'b0) : t) ^ kw[4'd15 - idx];
    end
    return t;
  endfunction

  state_t           state;
  logic [127:0]     blk;
  logic [127:0]     stage1;
  logic [127:0]     next_blk;
  logic [3:0]       rnd;
  logic [3:0]       nr;
  logic [3:0]       nr_in;
  logic             mode_q;
  logic [TAG_W-1:0] tag_q;
  logic             last_step;
  logic             accept;

  // Key size to round count
  always_comb begin
    case (key_size_i)
      2'b00:   nr_in = 4'd10;
      2'b01:   nr_in = 4'd12;
      default: nr_in = 4'd14;
    endcase
  end

  // Round datapath: one or two chained rounds per clock
  always_comb begin
    stage1 = do_round(blk, mode_q, rnd, nr, key_words_i);
    if (UNROLL == 2) begin
      next_blk = do_round(stage1, mode_q, rnd + 4'd1, nr, key_words_i);
    end else begin
      next_blk = stage1;
    end
  end

  assign last_step  = (rnd + STEP - 4'd1 == nr);
  assign in_ready_o = !reset && (state == IDLE || (state == DONE && out_ready_i));
  assign accept     = in_valid_i && in_ready_o;

  // Control FSM, round state and registered result
  always_ff @(posedge eph1 or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      blk         <= 128'd0;
      rnd         <= 4'd1;
      nr          <= 4'd10;
      mode_q      <= 1'b0;
      tag_q       <= '0;
      out_valid_o <= 1'b0;
      busy_o      <= 1'b0;
      data_o      <= 128'd0;
      tag_o       <= '0;
      mode_o      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
        end
        RUN: begin
          blk <= next_blk;
          if (last_step) begin
            state       <= DONE;
            out_valid_o <= 1'b1;
            busy_o      <= 1'b0;
            data_o      <= next_blk;
            tag_o       <= tag_q;
            mode_o      <= mode_q;
          end else begin
            rnd <= rnd + STEP;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      // A retiring result and a new request may share this edge
      if (accept) begin
        state  <= RUN;
        busy_o <= 1'b1;
        mode_q <= mode_i;
        nr     <= nr_in;
        tag_q  <= tag_i;
        rnd    <= 4'd1;
        blk    <= data_i ^ (mode_i ? key_words_i[4'd15 - nr_in] : key_words_i[15]);
      end
    end
  end

endmodule

// File: tb/tb_aes_crypt_engine.sv
// Directed bench for aes_crypt_engine: FIPS-197 App. C vectors at UNROLL=1 and 2,
// round trip, backpressure, back-to-back streaming and mid-block reset.
module tb_aes_crypt_engine;

  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] RT_PT  = 128'h27ECB2E3A5EE3894885B5289307400E3;
  localparam logic [255:0] K128   = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K192   = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K256   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               sel = 1'b0;
  logic               mode = 1'b0;
  logic               out_ready = 1'b1;
  logic [1:0]         key_size = 2'd0;
  logic [15:1][127:0] kw = '0;
  logic [127:0]       din = 128'd0;
  logic [3:0]         tag = 4'd0;

  logic         rdy0, ov0, mo0, busy0, rdy1, ov1, mo1, busy1;
  logic [127:0] dout0, dout1;
  logic [3:0]   tag0, tag1;
  logic         rdy, ov, mo, busy;
  logic [127:0] dout;
  logic [3:0]   tago;

  int total = 0;
  int bad   = 0;

  assign rdy  = sel ? rdy1  : rdy0;
  assign ov   = sel ? ov1   : ov0;
  assign mo   = sel ? mo1   : mo0;
  assign busy = sel ? busy1 : busy0;
  assign dout = sel ? dout1 : dout0;
  assign tago = sel ? tag1  : tag0;

  always #5 clk = ~clk;

  aes_crypt_engine #(.UNROLL(1), .TAG_W(4)) u1 (
    .eph1(clk), .reset(rst), .in_valid_i(in_valid & ~sel), .in_ready_o(rdy0),
    .mode_i(mode), .key_size_i(key_size), .key_words_i(kw), .data_i(din), .tag_i(tag),
    .out_valid_o(ov0), .out_ready_i(out_ready), .data_o(dout0), .tag_o(tag0),
    .mode_o(mo0), .busy_o(busy0)
  );

  aes_crypt_engine #(.UNROLL(2), .TAG_W(4)) u2 (
    .eph1(clk), .reset(rst), .in_valid_i(in_valid & sel), .in_ready_o(rdy1),
    .mode_i(mode), .key_size_i(key_size), .key_words_i(kw), .data_i(din), .tag_i(tag),
    .out_valid_o(ov1), .out_ready_i(out_ready), .data_o(dout1), .tag_o(tag1),
    .mode_o(mo1), .busy_o(busy1)
  );

  function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse by exhaustive search, then the bitwise affine map
  function automatic logic [7:0] tb_sbox(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] c;
    logic [7:0] s;
    inv = 8'h00;
    c   = 8'h63;
    for (int y = 1; y < 256; y++) if (tb_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
    for (int i = 0; i < 8; i++)
      s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
    return s;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] t);
    return {tb_sbox(t[31:24]), tb_sbox(t[23:16]), tb_sbox(t[15:8]), tb_sbox(t[7:0])};
  endfunction

  function automatic logic [255:0] key_of(input logic [1:0] ks);
    return (ks == 2'd0) ? K128 : (ks == 2'd1) ? K192 : K256;
  endfunction

  function automatic logic [127:0] ct_of(input logic [1:0] ks);
    return (ks == 2'd0) ? CT128 : (ks == 2'd1) ? CT192 : CT256;
  endfunction

  function automatic int nr_of(input logic [1:0] ks);
    return (ks == 2'd0) ? 10 : (ks == 2'd1) ? 12 : 14;
  endfunction

  task automatic load_keys(input logic [1:0] ks);
    logic [31:0]  w [60];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [255:0] key;
    int nk;
    int nr;
    key = key_of(ks);
    nr  = nr_of(ks);
    nk  = nr - 6;
    rc  = 8'h01;
    for (int i = 0; i < 4*(nr+1); i++) begin
      if (i < nk) begin
        w[i] = key[255 - 32*i -: 32];
      end else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
        end else if (nk > 6 && i % nk == 4) begin
          t = subword(t);
        end
        w[i] = w[i-nk] ^ t;
      end
    end
    kw = '0;
    for (int r = 0; r <= nr; r++) kw[15-r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic m, input logic [1:0] ks, input logic [127:0] d, input logic [3:0] t);
    mode = m; key_size = ks; din = d; tag = t;
    load_keys(ks);
  endtask

  task automatic start(input logic m, input logic [1:0] ks, input logic [127:0] d, input logic [3:0] t);
    drive(m, ks, d, t);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (ov !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    if (ov !== 1'b1) cyc = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      total++;
      if ({ov, busy, mo, tago, dout} !== 135'd0) begin
        bad++; $display("FAIL reset_outputs u%0d: got %h want 0", s, {ov, busy, mo, tago, dout});
      end
    end
    rst = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      total++;
      if (rdy !== 1'b1) begin bad++; $display("FAIL reset_in_ready u%0d: got %b want 1", s, rdy); end
    end
    tick();
  endtask

  task automatic test_fips(input int u);
    int c;
    int lat;
    sel = 1'(u);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      lat = nr_of(2'(k)) / (u + 1);
      for (int m = 0; m < 2; m++) begin
        start(1'(m), 2'(k), m ? ct_of(2'(k)) : PT, 4'(k + 4*m));
        total++;
        if (rdy !== 1'b0 || busy !== 1'b1) begin
          bad++; $display("FAIL run_flags u%0d ks%0d m%0d: got rdy=%b busy=%b want 0 1", u, k, m, rdy, busy);
        end
        wait_valid(c);
        total++;
        if (c !== lat) begin bad++; $display("FAIL latency u%0d ks%0d m%0d: got %0d want %0d", u, k, m, c, lat); end
        total++;
        if (dout !== (m ? PT : ct_of(2'(k)))) begin
          bad++; $display("FAIL data u%0d ks%0d m%0d: got %h want %h", u, k, m, dout, m ? PT : ct_of(2'(k)));
        end
        total++;
        if (tago !== 4'(k + 4*m) || mo !== 1'(m)) begin
          bad++; $display("FAIL tag_mode u%0d ks%0d m%0d: got %h/%b want %h/%b", u, k, m, tago, mo, 4'(k + 4*m), 1'(m));
        end
      end
    end
    tick();
  endtask

  task automatic test_round_trip();
    int c;
    logic [127:0] ct;
    sel = 1'b0;
    start(1'b0, 2'd2, RT_PT, 4'hA);
    wait_valid(c);
    ct = dout;
    total++;
    if (c !== 14 || tago !== 4'hA || mo !== 1'b0 || ct === RT_PT) begin
      bad++; $display("FAIL rt_encrypt: got lat=%0d tag=%h mode=%b ct=%h want 14 a 0 ct!=pt", c, tago, mo, ct);
    end
    start(1'b1, 2'd2, ct, 4'hA);
    wait_valid(c);
    total++;
    if (dout !== RT_PT) begin bad++; $display("FAIL rt_plain: got %h want %h", dout, RT_PT); end
    total++;
    if (tago !== 4'hA || mo !== 1'b1) begin bad++; $display("FAIL rt_tag: got %h/%b want a/1", tago, mo); end
  endtask

  task automatic test_backpressure();
    int c;
    sel = 1'b0;
    start(1'b0, 2'd0, PT, 4'h3);
    out_ready = 1'b0;
    wait_valid(c);
    total++;
    if (c !== 10) begin bad++; $display("FAIL bp_latency: got %0d want 10", c); end
    for (int i = 0; i < 20; i++) begin
      total++;
      if (ov !== 1'b1 || dout !== CT128 || tago !== 4'h3 || rdy !== 1'b0) begin
        bad++; $display("FAIL bp_hold cyc%0d: got ov=%b d=%h tag=%h rdy=%b want 1 %h 3 0", i, ov, dout, tago, rdy, CT128);
      end
      tick();
    end
    drive(1'b1, 2'd0, CT128, 4'h5);
    in_valid = 1'b1;
    #1;
    total++;
    if (rdy !== 1'b0) begin bad++; $display("FAIL bp_ready_low: got %b want 0", rdy); end
    out_ready = 1'b1;
    #1;
    total++;
    if (rdy !== 1'b1) begin bad++; $display("FAIL bp_ready_comb: got %b want 1", rdy); end
    tick();
    in_valid = 1'b0;
    total++;
    if (ov !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL bp_retire_accept: got ov=%b busy=%b want 0 1", ov, busy); end
    wait_valid(c);
    total++;
    if (c !== 10 || dout !== PT || tago !== 4'h5) begin
      bad++; $display("FAIL bp_next: got lat=%0d d=%h tag=%h want 10 %h 5", c, dout, tago, PT);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  md;
    logic [15:0] kss;
    logic [1:0]  ks;
    int c;
    sel = 1'b1;
    out_ready = 1'b1;
    md  = 8'b1010_1010;
    kss = {2'd0, 2'd3, 2'd1, 2'd2, 2'd2, 2'd1, 2'd0, 2'd0};
    ks  = kss[1:0];
    drive(md[0], ks, md[0] ? ct_of(ks) : PT, 4'd0);
    in_valid = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      ks = kss[2*i +: 2];
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept req%0d: got busy=%b want 1", i, busy); end
      wait_valid(c);
      total++;
      if (c !== nr_of(ks) / 2) begin bad++; $display("FAIL b2b_latency req%0d: got %0d want %0d", i, c, nr_of(ks) / 2); end
      total++;
      if (dout !== (md[i] ? PT : ct_of(ks)) || tago !== 4'(i) || mo !== md[i]) begin
        bad++; $display("FAIL b2b_result req%0d: got %h tag=%h mode=%b want %h %h %b", i, dout, tago, mo,
                        md[i] ? PT : ct_of(ks), 4'(i), md[i]);
      end
      total++;
      if (rdy !== 1'b1) begin bad++; $display("FAIL b2b_ready req%0d: got %b want 1", i, rdy); end
      if (i < 7) drive(md[i+1], kss[2*i+2 +: 2], md[i+1] ? ct_of(kss[2*i+2 +: 2]) : PT, 4'(i + 1));
      else in_valid = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset_midrun();
    int c;
    int stale;
    sel = 1'b0;
    out_ready = 1'b1;
    start(1'b0, 2'd0, PT, 4'h6);
    repeat (4) tick();
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({ov, busy, mo, tago, dout} !== 135'd0) begin
      bad++; $display("FAIL midrun_reset_outputs: got %h want 0", {ov, busy, mo, tago, dout});
    end
    tick();
    rst = 1'b0;
    #1;
    total++;
    if (rdy !== 1'b1) begin bad++; $display("FAIL midrun_in_ready: got %b want 1", rdy); end
    stale = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (ov !== 1'b0) stale++;
    end
    total++;
    if (stale !== 0) begin bad++; $display("FAIL midrun_stale: got %0d valid cycles want 0", stale); end
    start(1'b0, 2'd1, PT, 4'h9);
    wait_valid(c);
    total++;
    if (c !== 12 || dout !== CT192 || tago !== 4'h9) begin
      bad++; $display("FAIL midrun_next: got lat=%0d d=%h tag=%h want 12 %h 9", c, dout, tago, CT192);
    end
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fips(0);
    test_fips(1);
    test_round_trip();
    test_backpressure();
    test_back_to_back();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
